// File: rtl/snn_spike_decoder.sv
// snn_spike_decoder: windowed spike counting with argmax decode; SNN_SPIKE_DEC_SEG_EN enables the seven-segment encoder
module snn_spike_decoder #(
  parameter int WINDOW = 255,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [7:0]       spike_in,
  output logic [2:0]       winner,
  output logic [CNT_W-1:0] winner_cnt,
  output logic             none,
  output logic             valid,
  output logic             busy,
  output logic [6:0]       seg
);
  typedef enum logic [1:0] {IDLE, COUNT, SCAN, DONE} state_t;
  localparam logic [CNT_W-1:0] CMAX  = '1;
  localparam logic [15:0]      WLAST = 16'(WINDOW);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt [8];
  logic [15:0] wcnt;
  logic [2:0] step, best_idx, idx_nx;
  logic [CNT_W-1:0] best, best_nx;
  logic sample, last, gt, fin;
  assign sample  = ena && (state == IDLE || state == COUNT);
  assign last    = sample && (wcnt + 16'd1 == WLAST);
  assign gt      = cnt[step] > best;
  assign best_nx = gt ? cnt[step] : best;
  assign idx_nx  = gt ? step : best_idx;
  assign fin     = state == SCAN && step == 3'd7;
  assign busy    = state == SCAN || state == DONE;
  // next-state selection; the first enabled IDLE cycle is already window cycle 1
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = ena ? (last ? SCAN : COUNT) : IDLE;
      COUNT:   state_nx = last ? SCAN : COUNT;
      SCAN:    state_nx = step == 3'd7 ? DONE : SCAN;
      default: state_nx = ena ? COUNT : IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_nx;
  // per-line saturating spike counters, cleared once the decision is out
  for (genvar i = 0; i < 8; i++) begin : g_cnt
    always_ff @(posedge clk)
      if (!rst_n || state == DONE) cnt[i] <= '0;
      else if (sample && spike_in[i] && cnt[i] != CMAX) cnt[i] <= cnt[i] + CNT_W'(1);
  end
  // sampled-cycle counter; rewinds on the final sample of the window
  always_ff @(posedge clk)
    if (!rst_n || state == DONE) wcnt <= '0;
    else if (sample) wcnt <= last ? 16'd0 : wcnt + 16'd1;
  // sequential argmax; strict compare keeps the lowest index on ties
  always_ff @(posedge clk)
    if (!rst_n || state != SCAN) begin
      step     <= '0;
      best     <= '0;
      best_idx <= '0;
    end else begin
      step     <= step + 3'd1;
      best     <= best_nx;
      best_idx <= idx_nx;
    end
  // decision registers load on the last scan step so they are fresh during DONE
  always_ff @(posedge clk)
    if (!rst_n) begin
      winner     <= '0;
      winner_cnt <= '0;
      none       <= 1'b0;
      valid      <= 1'b0;
    end else begin
      valid <= fin;
      if (fin) begin
        winner     <= idx_nx;
        winner_cnt <= best_nx;
        none       <= best_nx == '0;
      end
    end
`ifdef SNN_SPIKE_DEC_SEG_EN
  function automatic logic [6:0] enc(input logic [2:0] d);
    case (d)
      3'd0:    enc = 7'b0111111;
      3'd1:    enc = 7'b0000110;
      3'd2:    enc = 7'b1011011;
      3'd3:    enc = 7'b1001111;
      3'd4:    enc = 7'b1100110;
      3'd5:    enc = 7'b1101101;
      3'd6:    enc = 7'b1111101;
      default: enc = 7'b0000111;
    endcase
  endfunction
  // display pattern follows the decision; blank when no line spiked
  always_ff @(posedge clk)
    if (!rst_n) seg <= '0;
    else if (fin) seg <= best_nx == '0 ? 7'd0 : enc(idx_nx);
`else
  assign seg = '0;
`endif
endmodule

// File: doc/snn_spike_decoder.md
# snn_spike_decoder

Output-side decoder for the tinysnn design. It counts spikes arriving on the eight output-neuron lines over a fixed sampling window and selects the line with the highest count (argmax). It then presents the winning neuron index, its count and a seven-segment digit for the display pins. It sits between the SNN neuron array and `uo_out`, and reads the spike trains the network produces.

## Interface
Parameters:
- `WINDOW`, default 255: number of sampled (ena-qualified) cycles per decision window; legal range is 1 to 65535.
- `CNT_W`, default 8: width of each per-line spike counter; counters saturate at 2^CNT_W-1.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `ena` input 1: sampling enable; when low, the window is paused.
- `spike_in` input 8: one spike line per output neuron; a high level for one cycle is one spike.
- `winner` output 3: index of the winning line.
- `winner_cnt` output CNT_W: spike count of the winning line.
- `none` output 1: high when every count in the window was 0.
- `valid` output 1: one-cycle strobe marking new `winner`, `winner_cnt` and `none` values.
- `busy` output 1: high in SCAN and DONE, while spikes are not being sampled.
- `seg` output 7: seven-segment pattern for `winner`; bit0 is segment a and bit6 is segment g; active-high.

## Operation
- FSM states are IDLE, COUNT, SCAN and DONE.
- IDLE:
  - All eight counters and the window counter are held at 0.
  - The block moves to COUNT on the first cycle with ena=1. That cycle is already sampled as window cycle 1.
- COUNT:
  - On each cycle with ena=1, `cnt[i]` increments for every i with spike_in[i]=1, saturating at the maximum; the window counter also increments.
  - When ena=0, all counters hold and the state stays COUNT.
  - After the WINDOW-th sampled cycle the block moves to SCAN.
- SCAN (8 cycles):
  - At scan step k (0..7), `cnt[k]` is compared against `best`. If it is strictly greater, `best` and `best_idx` are updated.
  - `best` and `best_idx` start at 0 at the beginning of every scan. With strict comparison, the lowest index wins a tie.
  - The block moves to DONE after step 7.
- DONE (1 cycle):
  - Output registers load: `winner`=best_idx, `winner_cnt`=best, `none`=(best==0), and `seg`=encode(best_idx), or 0 if none.
  - `valid`=1 for this one cycle only.
  - All counters are cleared.
  - Next state is COUNT if ena=1 (and that cycle is sampled as cycle 1 of the new window), otherwise IDLE.
- Spikes arriving during SCAN and DONE are discarded.
- `winner`, `winner_cnt`, `none` and `seg` hold their values until the next DONE.
- Digit encoding (gfedcba): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111.

## Timing
- Reset (rst_n=0 at a rising edge):
  - The state goes to IDLE.
  - All counters clear.
  - `winner`=0, `winner_cnt`=0, `none`=0, `valid`=0, `busy`=0 and `seg`=0 (blank).
- Reset has priority over every event, including in the middle of COUNT or SCAN. A window interrupted by reset produces no `valid`.
- Latency:
  - Let edge E be the edge that samples the final window cycle.
  - SCAN occupies the 8 cycles after E, and `busy`=1 during those 8 cycles plus DONE.
  - `valid` is high during the 9th cycle after E.
- With ena held at 1, the decision period is exactly WINDOW+9 cycles.
- A spike on the same cycle as the WINDOW-th sample is counted.
- Saturation: a counter at 2^CNT_W-1 stays there. Scanning compares saturated values as-is.
- With WINDOW=1, the block samples one cycle and then goes straight to SCAN.

## Configuration
- The macro is `SNN_SPIKE_DEC_SEG_EN`.
- When defined, the seven-segment encoder is instantiated and `seg` behaves as specified above.
- When undefined, `seg` is tied to 7'b0 and the encoder logic is absent. All other outputs and all timing are identical.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with random spike_in. Every output must read 0, and `valid` must never pulse.
- Single winner: WINDOW=16, ena=1, spike_in=8'b0000_1000 held constant.
  - `valid` pulses 25 cycles after the ena rise.
  - Expect winner=3, winner_cnt=16, none=0 and seg=1001111.
- Tie: WINDOW=16, lines 2 and 5 spike on alternate cycles (8 spikes each), all other lines 0. Expect winner=2, winner_cnt=8.
- Saturation and no-spike window:
  - CNT_W=4, WINDOW=20, line 7 high constantly: expect winner=7, winner_cnt=15.
  - The next window with spike_in=0: expect none=1, winner=0, winner_cnt=0 and seg=0.
- Pause: WINDOW=16, ena low for 5 cycles in the middle of the window, line 1 constant. `valid` arrives 5 cycles later than the no-pause case, with winner_cnt=16.
- Reset during scan: pull rst_n low in SCAN step 4.
  - `valid` does not pulse.
  - The outputs read 0.
  - The next window decodes normally.
